pll_lock_monitor: RTL and testbench
===================================

// Module: pll_lock_monitor
// PURPOSE
//  Digital lock/frequency monitor for the avsd PLL. Clocked by the PLL output CLK and reads REF.
//  Counts CLK cycles per REF period and checks each count against the expected multiplier.
//  Drives LOCK, frequency-error flags and a REF-loss indication to the SoC.
//  Consumes the PLL's CLK/REF relationship, the opposite direction of the PLL.
// PARAMETERS
//  MULT      8   expected CLK cycles per REF period
//  TOL       1   allowed |count-MULT| for a good period (absorbs synchronizer jitter)
//  LOCK_CNT  4   consecutive good periods needed to assert LOCK
//  UNLOCK_CNT 2  consecutive bad periods that drop LOCK
//  TIMEOUT   32  CLK cycles without a REF edge that declare REF lost
//  CNT_W     8   period counter width; legal only if MULT>TOL, MULT+TOL<TIMEOUT<=2^CNT_W-1
// PORTS
//  CLK       in   1      PLL output clock; the only clock
//  RST       in   1      asynchronous, active-high reset
//  EN        in   1      monitor enable, synchronous to CLK
//  REF       in   1      reference clock, asynchronous, treated as data
//  LOCK      out  1      PLL frequency locked
//  MEAS      out  CNT_W  last measured CLK count per REF period
//  MEAS_VLD  out  1      1-cycle pulse when MEAS updates
//  SLOW      out  1      last count < MULT-TOL
//  FAST      out  1      last count > MULT+TOL
//  REF_LOST  out  1      1-cycle pulse on timeout
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. Synchronizer, counters and the armed flag are cleared.
//  - REF passes through a 2-FF synchronizer plus a delay flop. ref_rise = s2 & ~s3.
//    ref_rise is high 2-3 CLK after the REF edge.
//  - States: IDLE, ACQUIRE, LOCKED. All outputs are registered.
//  - IDLE: cnt=0, armed=0, good=0, bad=0.
//    EN=1 moves to ACQUIRE on the next edge.
//    EN=0 in any state: next edge gives IDLE, LOCK=0, SLOW=FAST=0. MEAS holds.
//  - cnt: in ACQUIRE/LOCKED it increments every cycle and saturates at 2^CNT_W-1.
//    On ref_rise, cnt<=1 (the edge cycle is cycle 1 of the new period).
//  - First ref_rise after entering ACQUIRE only sets armed=1. No measurement is made.
//  - ref_rise with armed=1:
//    - MEAS<=cnt and MEAS_VLD=1 for one cycle.
//    - SLOW/FAST are updated on the same edge.
//    - A period is good when MULT-TOL <= cnt <= MULT+TOL.
//  - Good period: good<=sat(good+1, LOCK_CNT), bad<=0.
//    Bad period: bad<=sat(bad+1, UNLOCK_CNT), good<=0.
//  - ACQUIRE->LOCKED on the measurement that makes good==LOCK_CNT.
//    LOCK rises on the same edge as that MEAS_VLD.
//  - LOCKED->ACQUIRE on the measurement that makes bad==UNLOCK_CNT.
//    LOCK falls on that edge. armed stays 1 and good=0.
//  - Timeout: cnt==TIMEOUT with no ref_rise in that cycle. Effects on that edge:
//    - REF_LOST pulses and LOCK<=0.
//    - State goes to ACQUIRE; armed, good, bad are set to 0 and cnt is set to 0.
//  - ref_rise in the same cycle as cnt==TIMEOUT: ref_rise wins.
//    It counts as a bad measurement of TIMEOUT and REF_LOST does not pulse.
//  - Arithmetic: |cnt-MULT| is evaluated as unsigned two-sided compares. No subtraction wrap.
//  - RST mid-operation clears everything immediately and asynchronously.
//    After release, relock needs an arming edge plus LOCK_CNT good periods.
// STRUCTURE
//  - pll_mon_pkg: state enum {IDLE, ACQUIRE, LOCKED} and default constants (MULT, TOL, TIMEOUT).
//  - Sub-module ref_sync_edge: 2-FF synchronizer, delay flop and rise detect, with async reset.
//    Instantiated once.
//  - Top level holds the FSM, period counter, good/bad counters and output registers.
// TESTING
//  1. EN=1, REF period = 8 CLK. MEAS=8 at each edge after the arming edge.
//     LOCK rises with the 4th MEAS_VLD. SLOW=FAST=0.
//  2. REF period = 10 CLK. MEAS=10, FAST=1, LOCK stays 0.
//     Period 7/9 alternating reaches LOCK after 4 measurements.
//  3. While locked, one period of 6 then 8: SLOW pulses true, LOCK holds.
//     Two periods of 6: LOCK falls at the 2nd MEAS_VLD.
//  4. While locked, hold REF low. REF_LOST pulses when cnt==32 and LOCK=0.
//     The next REF edge only arms (no MEAS_VLD).
//  5. Assert RST while locked: outputs 0 immediately.
//     After release with period 8, LOCK returns after 1 arm + 4 measurements.
//  6. Drop EN while locked: LOCK=0 next edge, state IDLE.
//     Re-enable: arming edge first, then LOCK after 4 more good periods.

Source files
------------

// File: rtl/pll_mon_pkg.sv
// Shared state encoding and default constants for the PLL lock monitor.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DEF_MULT       = 8;
  localparam int DEF_TOL        = 1;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_UNLOCK_CNT = 2;
  localparam int DEF_TIMEOUT    = 32;
  localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/ref_sync_edge.sv
// Brings the asynchronous REF into the CLK domain and flags its rising edge.
module ref_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/pll_lock_monitor.sv
// Counts CLK cycles per REF period and derives LOCK, SLOW/FAST and REF-loss status.
// state   | meaning
// IDLE    | monitor disabled, all tracking cleared
// ACQUIRE | measuring, waiting for LOCK_CNT consecutive good periods
// LOCKED  | frequency locked, waiting for UNLOCK_CNT consecutive bad periods
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int MULT       = DEF_MULT,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             REF,
  output logic             LOCK,
  output logic [CNT_W-1:0] MEAS,
  output logic             MEAS_VLD,
  output logic             SLOW,
  output logic             FAST,
  output logic             REF_LOST
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  // Window bounds as unsigned compares; no subtraction on the live count.
  localparam logic [CNT_W-1:0] LO       = CNT_W'(MULT - TOL);
  localparam logic [CNT_W-1:0] HI       = CNT_W'(MULT + TOL);
  localparam logic [CNT_W-1:0] TO       = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_CNT);
  localparam logic [BW-1:0]    BAD_MAX  = BW'(UNLOCK_CNT);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             armed, armed_n;
  logic [GW-1:0]    good, good_n;
  logic [BW-1:0]    bad, bad_n;
  logic             lock_n, vld_n, slow_n, fast_n, lost_n;
  logic [CNT_W-1:0] meas_n;
  logic             ref_rise;
  logic             good_p;

  ref_sync_edge u_ref_sync (
    .clk  (CLK),
    .rst  (RST),
    .d    (REF),
    .rise (ref_rise)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      armed    <= 1'b0;
      good     <= '0;
      bad      <= '0;
      LOCK     <= 1'b0;
      MEAS     <= '0;
      MEAS_VLD <= 1'b0;
      SLOW     <= 1'b0;
      FAST     <= 1'b0;
      REF_LOST <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      armed    <= armed_n;
      good     <= good_n;
      bad      <= bad_n;
      LOCK     <= lock_n;
      MEAS     <= meas_n;
      MEAS_VLD <= vld_n;
      SLOW     <= slow_n;
      FAST     <= fast_n;
      REF_LOST <= lost_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    armed_n = armed;
    good_n  = good;
    bad_n   = bad;
    lock_n  = LOCK;
    meas_n  = MEAS;
    vld_n   = 1'b0;
    slow_n  = SLOW;
    fast_n  = FAST;
    lost_n  = 1'b0;
    good_p  = (cnt >= LO) && (cnt <= HI);

    if (!EN) begin
      state_n = IDLE;
      cnt_n   = '0;
      armed_n = 1'b0;
      good_n  = '0;
      bad_n   = '0;
      lock_n  = 1'b0;
      slow_n  = 1'b0;
      fast_n  = 1'b0;
    end else if (state == IDLE) begin
      state_n = ACQUIRE;
      cnt_n   = '0;
      armed_n = 1'b0;
      good_n  = '0;
      bad_n   = '0;
    end else if (ref_rise) begin
      // The edge cycle is cycle 1 of the next period; ref_rise beats a same-cycle timeout.
      cnt_n = CNT_W'(1);
      if (!armed) begin
        armed_n = 1'b1;
      end else begin
        meas_n = cnt;
        vld_n  = 1'b1;
        slow_n = (cnt < LO);
        fast_n = (cnt > HI);
        if (good_p) begin
          good_n = (good == GOOD_MAX) ? good : good + GW'(1);
          bad_n  = '0;
          if ((state == ACQUIRE) && (good_n == GOOD_MAX)) begin
            state_n = LOCKED;
            lock_n  = 1'b1;
          end
        end else begin
          bad_n  = (bad == BAD_MAX) ? bad : bad + BW'(1);
          good_n = '0;
          if ((state == LOCKED) && (bad_n == BAD_MAX)) begin
            state_n = ACQUIRE;
            lock_n  = 1'b0;
          end
        end
      end
    end else if (cnt == TO) begin
      state_n = ACQUIRE;
      cnt_n   = '0;
      armed_n = 1'b0;
      good_n  = '0;
      bad_n   = '0;
      lock_n  = 1'b0;
      lost_n  = 1'b1;
    end else if (cnt != '1) begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench for pll_lock_monitor: REF edges queue expected measurements, a monitor checks them.
module tb_pll_lock_monitor;

  logic       CLK, RST, EN, REF;
  logic       LOCK, MEAS_VLD, SLOW, FAST, REF_LOST;
  logic [7:0] MEAS;

  typedef struct {
    int m;
    bit s;
    bit f;
    bit l;
  } exp_t;

  exp_t meas_q[$];
  bit   lost_q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_meas = 0;

  pll_lock_monitor dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .REF      (REF),
    .LOCK     (LOCK),
    .MEAS     (MEAS),
    .MEAS_VLD (MEAS_VLD),
    .SLOW     (SLOW),
    .FAST     (FAST),
    .REF_LOST (REF_LOST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Enter at a negedge one cycle after the previous REF rise; raise REF gap cycles after it.
  task automatic step(input int gap, input bit chk, input int m, input bit s, input bit f, input bit l);
    exp_t e;
    repeat (gap - 1) @(negedge CLK);
    REF = 1'b1;
    if (chk) begin
      e.m = m; e.s = s; e.f = f; e.l = l;
      meas_q.push_back(e);
    end
    @(negedge CLK);
    REF = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!RST && MEAS_VLD) begin
      exp_t e;
      n_meas++;
      tests++;
      if (meas_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_meas_vld #%0d: got meas=%0d, expected no pulse", n_meas, MEAS);
      end else begin
        e = meas_q.pop_front();
        if ({MEAS, SLOW, FAST, LOCK} !== {8'(e.m), e.s, e.f, e.l}) begin
          fails++;
          $display("FAIL meas #%0d: got meas=%0d slow=%b fast=%b lock=%b, expected meas=%0d slow=%b fast=%b lock=%b",
                   n_meas, MEAS, SLOW, FAST, LOCK, e.m, e.s, e.f, e.l);
        end
      end
    end
    if (!RST && REF_LOST) begin
      tests++;
      if (lost_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ref_lost: got pulse, expected none (lock=%b)", LOCK);
      end else if (LOCK !== lost_q.pop_front()) begin
        fails++;
        $display("FAIL ref_lost_lock: got lock=%b, expected 0", LOCK);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b1; EN = 1'b0; REF = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_outputs", {LOCK, MEAS, MEAS_VLD, SLOW, FAST, REF_LOST}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    EN = 1'b1;
    @(negedge CLK);

    // nominal period: arm, then lock on the 4th measurement
    step(4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(8, 1, 8, 0, 0, 0);
    step(8, 1, 8, 0, 0, 1);

    // single short period holds lock, two in a row drop it
    step(6, 1, 6, 1, 0, 1);
    step(8, 1, 8, 0, 0, 1);
    step(6, 1, 6, 1, 0, 1);
    step(6, 1, 6, 1, 0, 0);

    // fast periods never lock; window edges 7/9 do
    for (int i = 0; i < 3; i++) step(10, 1, 10, 0, 1, 0);
    step(7, 1, 7, 0, 0, 0);
    step(9, 1, 9, 0, 0, 0);
    step(7, 1, 7, 0, 0, 0);
    step(9, 1, 9, 0, 0, 1);

    // REF edge coinciding with cnt==TIMEOUT is a bad measurement, not a loss
    step(32, 1, 32, 0, 1, 1);
    step(8, 1, 8, 0, 0, 1);

    // hold REF low: loss 35 cycles after the last REF rise
    lost_q.push_back(1'b0);
    n = 1;
    while (!REF_LOST && n < 80) begin
      @(negedge CLK);
      n++;
    end
    check("ref_lost_latency", n, 32'd35);
    check("lock_after_loss", LOCK, 32'd0);
    step(3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(8, 1, 8, 0, 0, 0);
    step(8, 1, 8, 0, 0, 1);

    // async reset while locked
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("async_reset_outputs", {LOCK, MEAS, MEAS_VLD, SLOW, FAST, REF_LOST}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    step(3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(8, 1, 8, 0, 0, 0);
    step(8, 1, 8, 0, 0, 1);

    // disable while locked, REF edge ignored in IDLE, then relock
    repeat (4) @(negedge CLK);
    EN = 1'b0;
    @(negedge CLK);
    check("disable_flags", {LOCK, SLOW, FAST}, 32'd0);
    check("disable_meas_hold", MEAS, 32'd8);
    step(3, 0, 0, 0, 0, 0);
    repeat (6) @(negedge CLK);
    EN = 1'b1;
    @(negedge CLK);
    step(3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(8, 1, 8, 0, 0, 0);
    step(8, 1, 8, 0, 0, 1);

    repeat (6) @(negedge CLK);
    check("meas_queue_drained", meas_q.size(), 32'd0);
    check("lost_queue_drained", lost_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
